// File: rtl/latch_bank_write_arbiter.sv
// Round-robin write arbiter for a bank of gated D latches.
// Each grant drives LD, pulses exactly one strobe, then holds LD before releasing the bank.
module latch_bank_write_arbiter #(
  parameter int NREQ       = 4,
  parameter int AW         = 3,
  parameter int DW         = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*AW-1:0]   i_addr,
  input  logic [NREQ*DW-1:0]   i_data,
  output logic [NREQ-1:0]      o_gnt,
  output logic [NREQ-1:0]      o_ack,
  output logic                 o_busy,
  output logic [DW-1:0]        o_ld,
  output logic [(2**AW)-1:0]   o_st,
  output logic [1:0]           o_dbg_state
);

  localparam int NST = 2**AW;
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [3:0] C_SETUP  = 4'(SETUP_CYC);
  localparam logic [3:0] C_STROBE = 4'(STROBE_CYC);
  localparam logic [3:0] C_HOLD   = 4'(HOLD_CYC);

  // Handshake: a requester holds i_req until its one-cycle o_ack; address and
  // data are captured on the grant edge, so they may change once o_gnt is seen.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [PW-1:0]     r_ptr;
  logic [AW-1:0]     r_addr;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_ack;
  logic              r_busy;
  logic [DW-1:0]     r_ld;
  logic [NST-1:0]    r_st;

  logic              w_any;
  logic [PW-1:0]     w_win;
  logic [PW-1:0]     w_next_ptr;
  logic [NREQ-1:0]   w_win_oh;
  logic [AW-1:0]     w_win_addr;
  logic [DW-1:0]     w_win_data;
  logic [NST-1:0]    w_st_oh;

  assign w_any = |i_req;

  // Scan from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    int            j;
    logic [PW-1:0] idx;
    j     = 0;
    idx   = '0;
    w_win = r_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = PW'(j);
      if (i_req[idx]) w_win = idx;
    end
  end

  assign w_next_ptr = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);

  always_comb begin
    w_win_oh   = '0;
    w_win_addr = '0;
    w_win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == PW'(i)) begin
        w_win_oh[i] = 1'b1;
        w_win_addr  = i_addr[i*AW +: AW];
        w_win_data  = i_data[i*DW +: DW];
      end
    end
  end

  assign w_st_oh = NST'(1) << r_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_busy  <= 1'b0;
      r_ld    <= '0;
      r_st    <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_win_oh;
            r_addr  <= w_win_addr;
            r_ld    <= w_win_data;
            r_ptr   <= w_next_ptr;
            r_busy  <= 1'b1;
            r_cnt   <= C_SETUP;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == 4'd1) begin
            r_st    <= w_st_oh;
            r_cnt   <= C_STROBE;
            r_state <= S_STROBE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_STROBE: begin
          if (r_cnt == 4'd1) begin
            r_st    <= '0;
            r_cnt   <= C_HOLD;
            r_state <= S_HOLD;
            if (C_HOLD == 4'd1) r_ack <= r_gnt;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (r_cnt == 4'd1) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            // ACK lands in the final HOLD cycle.
            if (r_cnt == 4'd2) r_ack <= r_gnt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_ack       = r_ack;
  assign o_busy      = r_busy;
  assign o_ld        = r_ld;
  assign o_st        = r_st;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Bench for latch_bank_write_arbiter: scoreboard of expected writes, cycle-exact
// timing checks, round-robin order, async reset mid-strobe, alternate timing build.
module tb_latch_bank_write_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int NST  = 8;
  localparam int SBW  = 2 + AW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NREQ-1:0]     req, req5;
  logic [NREQ*AW-1:0]  addr, addr5;
  logic [NREQ*DW-1:0]  data, data5;
  logic [NREQ-1:0]     gnt, ack, gnt5, ack5;
  logic                busy, busy5;
  logic [DW-1:0]       ld, ld5;
  logic [NST-1:0]      st, st5;
  logic [1:0]          dbg, dbg5;

  latch_bank_write_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_addr(addr), .i_data(data),
    .o_gnt(gnt), .o_ack(ack), .o_busy(busy), .o_ld(ld), .o_st(st), .o_dbg_state(dbg)
  );

  latch_bank_write_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)
  ) u_dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req5), .i_addr(addr5), .i_data(data5),
    .o_gnt(gnt5), .o_ack(ack5), .o_busy(busy5), .o_ld(ld5), .o_st(st5), .o_dbg_state(dbg5)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [SBW-1:0]  exp_q[$];
  int              ack_cyc[$];
  logic [DW-1:0]   latch_mem [NST];
  logic [NREQ-1:0] auto_drop;

  logic [NREQ-1:0] s_gnt, s_ack;
  logic            s_busy;
  logic [DW-1:0]   s_ld, m_prev_ld;
  logic [NST-1:0]  s_st, m_prev_st;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc_req(input logic [NREQ-1:0] v);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [AW-1:0] enc_st(input logic [NST-1:0] v);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < NST; i++) if (v[i]) r = AW'(i);
    return r;
  endfunction

  task automatic set_rq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit push);
    addr[i*AW +: AW] = a;
    data[i*DW +: DW] = d;
    if (push) exp_q.push_back({2'(i), a, d});
  endtask

  // Sample on the falling edge; run the bus monitor and latch model.
  task automatic sample();
    logic [SBW-1:0] e;
    @(negedge clk);
    s_gnt  = gnt;
    s_ack  = ack;
    s_busy = busy;
    s_ld   = ld;
    s_st   = st;
    if (!rst_n) begin
      m_prev_st = '0;
      m_prev_ld = '0;
      return;
    end
    if (st != '0) begin
      check_val("st_onehot", 32'($onehot(st)), 32'd1);
      latch_mem[enc_st(st)] = ld;
    end
    if (st != '0 || m_prev_st != '0) check_val("ld_stable_around_st", 32'(ld), 32'(m_prev_ld));
    if (st != '0 && m_prev_st == '0) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_write", 32'({enc_req(gnt), enc_st(st), ld}), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_val("sb_write", 32'({enc_req(gnt), enc_st(st), ld}), 32'(e));
      end
    end
    if (ack != '0) begin
      check_val("ack_matches_gnt", 32'(ack), 32'(gnt));
      ack_cyc.push_back(cyc);
    end
    m_prev_st = st;
    m_prev_ld = ld;
  endtask

  // One cycle: sample, then just after the edge drop REQ of requesters acked.
  task automatic step();
    sample();
    @(posedge clk);
    #1;
    req = req & ~(s_ack & auto_drop);
    cyc++;
  endtask

  task automatic wait_acks(input string tag, input int n, input int budget);
    int got;
    int k;
    got = 0;
    k   = 0;
    while (got < n && k < budget) begin
      step();
      if (s_ack != '0) got++;
      k++;
    end
    check_val(tag, 32'(got), 32'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    req5  = '0;
    #1;
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_ack", 32'(ack), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_st", 32'(st), 32'd0);
    check_val("rst_ld", 32'(ld), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    m_prev_st = '0;
    m_prev_ld = '0;
    cyc       = 0;
    ack_cyc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a_t;
    logic [DW-1:0] d_t;
    rst_n = 1'b0;
    req = '0; addr = '0; data = '0;
    req5 = '0; addr5 = '0; data5 = '0;
    auto_drop = '1;
    m_prev_st = '0; m_prev_ld = '0;
    for (int i = 0; i < NST; i++) latch_mem[i] = '0;

    // Single write, cycle-exact
    do_reset();
    set_rq(0, 3'd5, 8'hA5, 1'b1);
    req = 4'b0001;
    for (int k = 0; k < 7; k++) begin
      step();
      check_val($sformatf("t1_gnt_c%0d", k), 32'(s_gnt), (k >= 1 && k <= 4) ? 32'd1 : 32'd0);
      check_val($sformatf("t1_st_c%0d", k), 32'(s_st), (k == 2 || k == 3) ? 32'h20 : 32'd0);
      check_val($sformatf("t1_ack_c%0d", k), 32'(s_ack), (k == 4) ? 32'd1 : 32'd0);
      check_val($sformatf("t1_busy_c%0d", k), 32'(s_busy), (k >= 1 && k <= 4) ? 32'd1 : 32'd0);
      check_val($sformatf("t1_ld_c%0d", k), 32'(s_ld), (k >= 1) ? 32'hA5 : 32'd0);
    end
    check_val("t1_latch5", 32'(latch_mem[5]), 32'hA5);

    // All four requesting together
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a_t = AW'($urandom_range(0, NST - 1));
      d_t = DW'($urandom_range(0, 255));
      set_rq(i, a_t, d_t, 1'b1);
    end
    req = 4'b1111;
    wait_acks("t2_acks", 4, 40);
    if (ack_cyc.size() >= 4) begin
      check_val("t2_first_ack", 32'(ack_cyc[0]), 32'd4);
      for (int i = 1; i < 4; i++) check_val("t2_ack_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd5);
    end
    repeat (3) step();
    check_val("t2_idle_busy", 32'(s_busy), 32'd0);

    // Held requester 2 yields to late requester 1; captured data survives changes
    do_reset();
    auto_drop = 4'b1011;
    set_rq(2, 3'd1, 8'h21, 1'b1);
    req = 4'b0100;
    step();
    step();
    set_rq(1, 3'd6, 8'h16, 1'b1);
    set_rq(2, 3'd4, 8'h42, 1'b1);
    req[1] = 1'b1;
    wait_acks("t3_ack_first", 1, 20);
    auto_drop = '1;
    wait_acks("t3_ack_rest", 2, 30);
    repeat (4) step();
    check_val("t3_no_regrant", 32'(s_gnt), 32'd0);
    check_val("t3_latch1", 32'(latch_mem[1]), 32'h21);
    check_val("t3_latch4", 32'(latch_mem[4]), 32'h42);

    // Async reset mid-strobe, then pointer restarts at 0
    do_reset();
    set_rq(0, 3'd5, 8'h3C, 1'b1);
    req = 4'b0001;
    step();
    step();
    sample();
    check_val("t4_st_before_rst", 32'(s_st), 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t4_rst_st", 32'(st), 32'd0);
    check_val("t4_rst_gnt", 32'(gnt), 32'd0);
    check_val("t4_rst_busy", 32'(busy), 32'd0);
    check_val("t4_rst_ld", 32'(ld), 32'd0);
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_prev_st = '0;
    m_prev_ld = '0;
    cyc = 0;
    set_rq(0, 3'd2, 8'h11, 1'b1);
    set_rq(1, 3'd6, 8'h22, 1'b1);
    req = 4'b0011;
    step();
    step();
    check_val("t4_first_gnt", 32'(s_gnt), 32'd1);
    wait_acks("t4_acks", 2, 30);

    // Requester 3 drops REQ mid-write
    do_reset();
    set_rq(3, 3'd7, 8'h5A, 1'b1);
    req = 4'b1000;
    step();
    step();
    req[3] = 1'b0;
    wait_acks("t6_ack3", 1, 20);
    repeat (5) step();
    check_val("t6_no_regrant_gnt", 32'(s_gnt), 32'd0);
    check_val("t6_no_regrant_busy", 32'(s_busy), 32'd0);
    check_val("t6_latch7", 32'(latch_mem[7]), 32'h5A);

    // SETUP=3 STROBE=1 HOLD=2 build
    do_reset();
    addr5[AW-1:0] = 3'd3;
    data5[DW-1:0] = 8'h77;
    req5 = 4'b0001;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check_val($sformatf("t5_st_c%0d", k), 32'(st5), (k == 4) ? 32'h08 : 32'd0);
      check_val($sformatf("t5_ack_c%0d", k), 32'(ack5), (k == 6) ? 32'd1 : 32'd0);
      check_val($sformatf("t5_busy_c%0d", k), 32'(busy5), (k >= 1 && k <= 6) ? 32'd1 : 32'd0);
      check_val($sformatf("t5_gnt_c%0d", k), 32'(gnt5), (k >= 1 && k <= 6) ? 32'd1 : 32'd0);
      check_val($sformatf("t5_ld_c%0d", k), 32'(ld5), (k >= 1) ? 32'h77 : 32'd0);
      @(posedge clk);
      #1;
      if (k == 6) req5 = '0;
    end

    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
